// File: rtl/peripheral_ahb3_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_ahb3_pkg
//   Shared AHB3-Lite encodings for the tile peripherals (initiator and slaves).
//   Contents:
//     HTRANS_*  transfer type encodings
//     HSIZE_*   transfer size encodings
//     HBURST_*  burst type encodings
//     HRESP_*   response encodings (AHB-Lite: OKAY / ERROR)
//     ahb3_err_state_e  initiator error-response tracking states
// -----------------------------------------------------------------------------
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HWORD   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;
    localparam logic [2:0] HSIZE_QWORD   = 3'b100;
    localparam logic [2:0] HSIZE_OWORD   = 3'b101;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // OK: normal operation. ERR2: second cycle of a two-cycle ERROR response.
    typedef enum logic {
        StOk,
        StErr2
    } ahb3_err_state_e;

endpackage

// File: rtl/peripheral_ahb3_initiator_if.sv
// -----------------------------------------------------------------------------
// peripheral_ahb3_initiator_if
//   AHB3-Lite bus bundle between one initiator and the interconnect.
//   Parameters: PLEN (address width), XLEN (data width).
//   Modports:
//     master : drives address/control/write data, receives HRDATA/HREADY/HRESP
//     slave  : the opposite view, used by interconnect models and benches
// -----------------------------------------------------------------------------
interface peripheral_ahb3_initiator_if #(
    parameter int unsigned PLEN = 64,
    parameter int unsigned XLEN = 64
) ();

    logic [PLEN-1:0] HADDR;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HREADY;
    logic            HRESP;

    modport master (
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/peripheral_ahb3_initiator.sv
// -----------------------------------------------------------------------------
// peripheral_ahb3_initiator
//   Single-transfer AHB3-Lite initiator. Turns a native req/ack request port
//   into pipelined NONSEQ transfers and returns responses in issue order.
//
//   Ports:
//     HCLK, HRESETn  clock (rising edge), asynchronous active-low reset
//     req_i/ack_o    request valid / accepted this cycle (ack_o combinational)
//     we_i, addr_i, size_i, wdata_i  request attributes (wdata on byte lanes)
//     rsp_valid_o    transfer completed this cycle (combinational)
//     rsp_rdata_o    read data (HRDATA passthrough, zero for writes)
//     rsp_err_o      transfer ended in ERROR or was cancelled
//     ahb            AHB3-Lite master modport
//
//   Pipeline: A stage holds the address phase (HADDR/HTRANS/... plus the write
//   data waiting for its data phase); D stage tracks the data phase currently
//   on the bus. An ERROR response forces A to IDLE; a NONSEQ already parked in
//   A is cancelled and reported with an error right after the ERROR pair.
// -----------------------------------------------------------------------------
module peripheral_ahb3_initiator
    import peripheral_ahb3_pkg::*;
#(
    parameter int unsigned PLEN      = 64,
    parameter int unsigned XLEN      = 64,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,

    input  logic                         req_i,
    output logic                         ack_o,
    input  logic                         we_i,
    input  logic [PLEN-1:0]              addr_i,
    input  logic [2:0]                   size_i,
    input  logic [XLEN-1:0]              wdata_i,

    output logic                         rsp_valid_o,
    output logic [XLEN-1:0]              rsp_rdata_o,
    output logic                         rsp_err_o,

    peripheral_ahb3_initiator_if.master  ahb
);

    // A stage (address phase)
    logic [1:0]      htrans_q;
    logic [PLEN-1:0] haddr_q;
    logic            hwrite_q;
    logic [2:0]      hsize_q;
    logic [XLEN-1:0] wdata_hold_q;

    // D stage (data phase)
    logic            d_valid_q;
    logic            d_we_q;
    logic            d_cancel_q;
    logic [XLEN-1:0] hwdata_q;

    // A NONSEQ killed by an error waits here until the ERROR pair finishes,
    // since D is still occupied by the failing transfer.
    logic            cancel_pend_q;
    logic            cancel_we_q;

    ahb3_err_state_e state_q;

    logic a_nonseq;
    logic err_first;
    logic a_free;
    logic addr_done;

    always_comb begin
        a_nonseq  = (htrans_q == HTRANS_NONSEQ);
        err_first = (state_q == StOk) & d_valid_q & (ahb.HRESP == HRESP_ERROR) & ~ahb.HREADY;
        a_free    = ((htrans_q == HTRANS_IDLE) | ahb.HREADY) & ~err_first & (state_q == StOk);
        addr_done = a_nonseq & ahb.HREADY;
    end

    assign ack_o       = req_i & a_free;
    assign rsp_valid_o = d_valid_q & ahb.HREADY;
    assign rsp_err_o   = d_valid_q & ((ahb.HRESP == HRESP_ERROR) | d_cancel_q);
    assign rsp_rdata_o = d_we_q ? '0 : ahb.HRDATA;

    assign ahb.HADDR     = haddr_q;
    assign ahb.HWRITE    = hwrite_q;
    assign ahb.HSIZE     = hsize_q;
    assign ahb.HTRANS    = htrans_q;
    assign ahb.HWDATA    = hwdata_q;
    assign ahb.HBURST    = HBURST_SINGLE;
    assign ahb.HPROT     = HPROT_VAL;
    assign ahb.HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            htrans_q      <= HTRANS_IDLE;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            hsize_q       <= HSIZE_BYTE;
            wdata_hold_q  <= '0;
            d_valid_q     <= 1'b0;
            d_we_q        <= 1'b0;
            d_cancel_q    <= 1'b0;
            hwdata_q      <= '0;
            cancel_pend_q <= 1'b0;
            cancel_we_q   <= 1'b0;
            state_q       <= StOk;
        end else begin
            // Error FSM
            unique case (state_q)
                StOk:    if (err_first) state_q <= StErr2;
                StErr2:  if (ahb.HREADY) state_q <= StOk;
                default: state_q <= StOk;
            endcase

            // A stage
            if (err_first) begin
                htrans_q <= HTRANS_IDLE;
                if (a_nonseq) begin
                    cancel_pend_q <= 1'b1;
                    cancel_we_q   <= hwrite_q;
                end
            end else if (a_free) begin
                if (req_i) begin
                    htrans_q     <= HTRANS_NONSEQ;
                    haddr_q      <= addr_i;
                    hwrite_q     <= we_i;
                    hsize_q      <= size_i;
                    wdata_hold_q <= wdata_i;
                end else begin
                    htrans_q <= HTRANS_IDLE;
                end
            end

            // D stage
            if ((state_q == StErr2) && ahb.HREADY && cancel_pend_q) begin
                // Cancelled transfer takes its turn in order, never touching the bus.
                d_valid_q     <= 1'b1;
                d_we_q        <= cancel_we_q;
                d_cancel_q    <= 1'b1;
                cancel_pend_q <= 1'b0;
            end else if (addr_done) begin
                d_valid_q  <= 1'b1;
                d_we_q     <= hwrite_q;
                d_cancel_q <= 1'b0;
                hwdata_q   <= wdata_hold_q;
            end else if (ahb.HREADY) begin
                d_valid_q  <= 1'b0;
                d_cancel_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/peripheral_ahb3_initiator.md
# peripheral_ahb3_initiator

AHB3-Lite single-transfer bus initiator: converts a simple native request/response port into pipelined AHB-Lite transfers and returns read data and errors in issue order. It sits between a core-side load/store or DMA engine and the tile AHB interconnect. It is the master-side counterpart of the tile's multi-port SRAM AHB slave. It supports back-to-back pipelined transfers, slave wait states and two-cycle ERROR responses.

## Interface
- PLEN, 64, address width
- XLEN, 64, data width
- HPROT_VAL, 4'b0011, constant HPROT (non-cacheable, non-bufferable, privileged, data)

- HCLK  in  1  clock, rising edge
- HRESETn  in  1  asynchronous active-low reset
- req_i  in  1  request valid
- ack_o  out  1  request accepted this cycle (combinational)
- we_i  in  1  1 = write
- addr_i  in  PLEN  byte address
- size_i  in  3  HSIZE encoding
- wdata_i  in  XLEN  write data, already on correct byte lanes
- rsp_valid_o  out  1  transfer completed (combinational)
- rsp_rdata_o  out  XLEN  read data (HRDATA passthrough)
- rsp_err_o  out  1  transfer ended in ERROR or was cancelled
- HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK  out  PLEN/1/3/3/4/2/1  AHB address-phase signals, registered
- HWDATA  out  XLEN  write data, registered
- HRDATA  in  XLEN;  HREADY  in  1;  HRESP  in  1

## Operation
- Two register stages: address stage (A) drives HADDR/HWRITE/HSIZE/HTRANS plus held wdata; data stage (D) holds valid, we, cancel flag and drives HWDATA.
- A is free when HTRANS==IDLE or HREADY==1, and no error is in progress. ack_o = req_i & A-free. On ack, A loads the request with HTRANS=NONSEQ. If A is free and no request arrives, A loads HTRANS=IDLE.
- Address phase completes when HTRANS==NONSEQ & HREADY==1. D then loads valid=1 and the transfer's we. HWDATA loads the held wdata. Otherwise, when HREADY==1, D valid clears.
- rsp_valid_o = D.valid & HREADY. rsp_err_o = HRESP at that cycle, or the cancel flag. rsp_rdata_o = HRDATA for reads and don't-care for writes.
- Error handling: the state machine is OK / ERR2.
  - OK -> ERR2 when D.valid & HRESP & ~HREADY (first error cycle).
  - In that cycle A is forced to HTRANS=IDLE at the next edge. Any NONSEQ held in A is cancelled: it moves to D with cancel=1 and is never seen by a slave.
  - ERR2 -> OK on HREADY. ack_o is 0 in the first error cycle and in ERR2.
  - The cancelled transfer reports rsp_valid_o with rsp_err_o=1 on the first cycle after ERR2, in order.
- HBURST=SINGLE, HMASTLOCK=0, HPROT=HPROT_VAL always. HTRANS is never BUSY or SEQ.
- Unaligned addr_i or size_i wider than XLEN is caller error. It is driven unchanged.

## Timing
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, D.valid=0, state OK. Hence ack_o=req_i and rsp_valid_o=0 out of reset.
- Zero-wait latency: req/ack at cycle n, NONSEQ on bus n+1, rsp_valid_o at n+2.
- Throughput: one transfer per cycle when HREADY stays high.
- Wait states: A, D and HWDATA hold while HREADY==0.
- Reset mid-transfer: all state clears asynchronously and no response is issued for in-flight transfers.

## Structure
- HTRANS_*, HSIZE_*, HBURST_SINGLE and HRESP_* come from peripheral_ahb3_pkg. Add HRESP_ERROR there if absent.
- No sub-module: one module with A/D registers and the two-state error FSM.

## Test plan
- Single read at 0x40 with HREADY=1 and HRDATA=0x1122334455667788 -> NONSEQ at n+1, rsp_valid_o at n+2 with that data and err=0.
- Four back-to-back writes to 0x0/0x8/0x10/0x18 -> four consecutive NONSEQ cycles; HWDATA lags HADDR by exactly one cycle; four responses.
- Read with 3 wait states -> HADDR/HTRANS of the next request frozen; rsp_valid_o only on the 4th data cycle.
- Write to 0x100 answered with an ERROR pair while a read of 0x108 is in A -> HTRANS goes IDLE in the second error cycle; write completes err=1; read completes err=1 the next cycle; no read on the bus.
- HRESETn pulsed low during a wait state -> outputs immediately at reset values; the first post-reset request is issued normally.
